// File: rtl/pcie_tlp_tx_drain.sv
// Store-and-forward drain of complete TLPs from the decap FIFO onto the PCIe core's 64-bit AXIS TX port.
// Optional statistics counters are enabled with `define TLP_TX_STATS_EN.
package pcie_tlp_tx_pkg;
  typedef struct packed {
    logic        tvalid;
    logic        tlast;
    logic [7:0]  tkeep;
    logic [63:0] tdata;
    logic [3:0]  tuser;
  } tlp_axis_t;

  typedef struct packed {
    logic      data_valid;
    tlp_axis_t tlp;
  } PCIE_FIFO64_TX;
endpackage

module pcie_tlp_tx_drain
  import pcie_tlp_tx_pkg::*;
#(
  parameter int PKT_CNT_W = 6,
  parameter int MAX_BEATS = 80
) (
  input  logic          pcie_clk,
  input  logic          pcie_rst,
  input  logic          pkt_req,
  output logic          fifo_rd_en,
  input  PCIE_FIFO64_TX fifo_dout,
  input  logic          fifo_empty,
  output logic          s_axis_tx_tvalid,
  input  logic          s_axis_tx_tready,
  output logic          s_axis_tx_tlast,
  output logic [7:0]    s_axis_tx_tkeep,
  output logic [63:0]   s_axis_tx_tdata,
  output logic [3:0]    s_axis_tx_tuser
`ifdef TLP_TX_STATS_EN
  ,
  output logic [31:0]   stat_pkts,
  output logic [31:0]   stat_dsc,
  output logic [31:0]   stat_bubbles
`endif
);

  typedef enum logic [1:0] {IDLE, XFER, FLUSH} state_t;

  state_t               state;
  logic [PKT_CNT_W-1:0] pkt_cnt;
  logic [7:0]           beat_cnt;

  logic can_load;
  logic head_ok;
  logic head_bubble;
  logic start_ok;
  logic active;
  logic flush_pop;
  logic idle_bubble;
  logic is_beat;
  logic is_trunc;
  logic at_limit;
  logic forced;
  logic load_beat;
  logic load_last;
  logic unused_tuser;

  assign unused_tuser = ^fifo_dout.tlp.tuser;

  assign can_load    = !s_axis_tx_tvalid || s_axis_tx_tready;
  assign head_ok     = !fifo_empty;
  assign head_bubble = head_ok && !fifo_dout.data_valid;
  assign start_ok    = (state == IDLE) && head_ok && fifo_dout.data_valid &&
                       (pkt_cnt != '0) && can_load;
  // "active" means the head entry is consumed as part of the current packet this cycle
  assign active      = start_ok || ((state == XFER) && head_ok && can_load);
  assign flush_pop   = (state == FLUSH) && head_ok;
  assign idle_bubble = (state == IDLE) && head_bubble;

  assign is_beat   = fifo_dout.data_valid && fifo_dout.tlp.tvalid;
  assign is_trunc  = fifo_dout.data_valid && !fifo_dout.tlp.tvalid && fifo_dout.tlp.tlast;
  assign at_limit  = (beat_cnt == 8'(MAX_BEATS - 1));
  assign forced    = is_beat && at_limit && !fifo_dout.tlp.tlast;
  assign load_beat = active && (is_beat || is_trunc);
  assign load_last = active && (is_trunc || (is_beat && (fifo_dout.tlp.tlast || at_limit)));

  assign fifo_rd_en = !pcie_rst && (idle_bubble || active || flush_pop);

  always_ff @(posedge pcie_clk) begin
    if (pcie_rst) begin
      state            <= IDLE;
      pkt_cnt          <= '0;
      beat_cnt         <= '0;
      s_axis_tx_tvalid <= 1'b0;
      s_axis_tx_tlast  <= 1'b0;
      s_axis_tx_tkeep  <= '0;
      s_axis_tx_tdata  <= '0;
      s_axis_tx_tuser  <= '0;
    end else begin
      case ({pkt_req, load_last})
        2'b10:   if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   if (pkt_cnt != '0) pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase

      if (can_load) begin
        s_axis_tx_tvalid <= load_beat;
        if (load_beat) begin
          s_axis_tx_tdata <= is_trunc ? 64'h0 : fifo_dout.tlp.tdata;
          s_axis_tx_tkeep <= is_trunc ? 8'hFF : fifo_dout.tlp.tkeep;
          s_axis_tx_tlast <= load_last;
          s_axis_tx_tuser <= (is_trunc || forced) ? 4'h8 : 4'h0;
        end
      end

      if (active && fifo_dout.data_valid) begin
        if (is_trunc || (is_beat && fifo_dout.tlp.tlast)) begin
          state    <= IDLE;
          beat_cnt <= '0;
        end else if (forced) begin
          state    <= FLUSH;
          beat_cnt <= '0;
        end else begin
          state <= XFER;
          if (is_beat) beat_cnt <= beat_cnt + 1'b1;
        end
      end else if (flush_pop && fifo_dout.data_valid && fifo_dout.tlp.tlast) begin
        state <= IDLE;
      end
    end
  end

`ifdef TLP_TX_STATS_EN
  always_ff @(posedge pcie_clk) begin
    if (pcie_rst) begin
      stat_pkts    <= '0;
      stat_dsc     <= '0;
      stat_bubbles <= '0;
    end else begin
      if (s_axis_tx_tvalid && s_axis_tx_tready) begin
        if (s_axis_tx_tlast)    stat_pkts <= stat_pkts + 1'b1;
        if (s_axis_tx_tuser[3]) stat_dsc  <= stat_dsc + 1'b1;
      end
      if (fifo_rd_en && head_bubble) stat_bubbles <= stat_bubbles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pcie_tlp_tx_drain.sv
// Randomized bench for pcie_tlp_tx_drain: FWFT FIFO model, packet-level reference of expected AXIS beats.
module tb_pcie_tlp_tx_drain;
  import pcie_tlp_tx_pkg::*;

  localparam int MAXB = 4;

  logic          pcie_clk = 1'b0;
  logic          pcie_rst = 1'b1;
  logic          pkt_req = 1'b0;
  logic          fifo_rd_en;
  PCIE_FIFO64_TX fifo_dout = '0;
  logic          fifo_empty = 1'b1;
  logic          tvalid;
  logic          tready = 1'b0;
  logic          tlast;
  logic [7:0]    tkeep;
  logic [63:0]   tdata;
  logic [3:0]    tuser;
`ifdef TLP_TX_STATS_EN
  logic [31:0]   stat_pkts, stat_dsc, stat_bubbles;
`endif

  always #5 pcie_clk = ~pcie_clk;

  pcie_tlp_tx_drain #(.PKT_CNT_W(6), .MAX_BEATS(MAXB)) dut (
    .pcie_clk(pcie_clk),
    .pcie_rst(pcie_rst),
    .pkt_req(pkt_req),
    .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty),
    .s_axis_tx_tvalid(tvalid),
    .s_axis_tx_tready(tready),
    .s_axis_tx_tlast(tlast),
    .s_axis_tx_tkeep(tkeep),
    .s_axis_tx_tdata(tdata),
    .s_axis_tx_tuser(tuser)
`ifdef TLP_TX_STATS_EN
    ,
    .stat_pkts(stat_pkts),
    .stat_dsc(stat_dsc),
    .stat_bubbles(stat_bubbles)
`endif
  );

  PCIE_FIFO64_TX fifo_q[$];
  logic [76:0]   exp_q[$];   // {tlast, tuser, tkeep, tdata}
  int            n_cmp = 0;
  int            n_bad = 0;
  bit            pop_pending = 0;
  int            ready_pct = 100;
  bit            prev_stall = 0;
  logic [76:0]   prev_out = '0;
  logic [76:0]   cur_out;
  int            m_pkts = 0, m_dsc = 0, m_bub = 0;
  bit            seen;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: apply the previous pop, present the new FIFO head and tready, then observe the DUT.
  task automatic step();
    @(negedge pcie_clk);
    if (pop_pending && fifo_q.size() != 0) begin
      if (!fifo_q[0].data_valid) m_bub++;
      void'(fifo_q.pop_front());
    end
    pop_pending = 0;
    fifo_empty  = (fifo_q.size() == 0);
    fifo_dout   = fifo_empty ? '0 : fifo_q[0];
    tready      = ($urandom_range(99) < ready_pct);
    #1;
    if (fifo_empty) check("rd_en_when_empty", 80'(fifo_rd_en), 80'(0));
    pop_pending = fifo_rd_en && !fifo_empty;
    cur_out = {tlast, tuser, tkeep, tdata};
    if (prev_stall) check("hold_while_stalled", {2'b0, tvalid, cur_out}, {2'b0, 1'b1, prev_out});
    prev_stall = tvalid && !tready;
    prev_out   = cur_out;
    if (tvalid && tready) begin
      if (exp_q.size() == 0) check("unexpected_beat", {3'b001, cur_out}, 80'(0));
      else begin
        $display("beat tlast=%0b tuser=%h tkeep=%h tdata=%h", tlast, tuser, tkeep, tdata);
        check("beat", {3'b0, cur_out}, {3'b0, exp_q.pop_front()});
      end
      if (tlast) m_pkts++;
      if (tuser[3]) m_dsc++;
    end
    if (pcie_rst) begin
      m_pkts = 0; m_dsc = 0; m_bub = 0;
      pop_pending = 0;
      prev_stall = 0;
    end
  endtask

  task automatic push_bubble();
    PCIE_FIFO64_TX e;
    e = '0;
    e.tlp.tvalid = 1'($urandom);
    e.tlp.tkeep  = 8'($urandom);
    e.tlp.tdata  = {$urandom, $urandom};
    fifo_q.push_back(e);
  endtask

  // Writes one packet into the FIFO and appends what the PCIe core must see for it.
  task automatic push_packet(input int nbeats, input bit trunc, input bit directed);
    PCIE_FIFO64_TX e;
    bit done;
    int total;
    done  = 0;
    total = nbeats + (trunc ? 1 : 0);
    for (int k = 0; k < total; k++) begin
      if (!directed && $urandom_range(4) == 0) push_bubble();
      e = '0;
      e.data_valid = 1'b1;
      if (trunc && k == nbeats) begin
        e.tlp.tlast = 1'b1;
        e.tlp.tkeep = 8'($urandom);
        e.tlp.tdata = {$urandom, $urandom};
      end else begin
        e.tlp.tvalid = 1'b1;
        e.tlp.tlast  = !trunc && (k == nbeats - 1);
        e.tlp.tkeep  = e.tlp.tlast ? (directed ? 8'h0F : 8'($urandom_range(1, 255))) : 8'hFF;
        e.tlp.tdata  = directed ? {8{8'(8'h11 * (k + 1))}} : {$urandom, $urandom};
        e.tlp.tuser  = 4'($urandom);
      end
      fifo_q.push_back(e);
      if (!done) begin
        if (!e.tlp.tvalid) begin
          exp_q.push_back({1'b1, 4'h8, 8'hFF, 64'h0});
          done = 1;
        end else if (k == MAXB - 1 && !e.tlp.tlast) begin
          exp_q.push_back({1'b1, 4'h8, e.tlp.tkeep, e.tlp.tdata});
          done = 1;
        end else begin
          exp_q.push_back({e.tlp.tlast, 4'h0, e.tlp.tkeep, e.tlp.tdata});
          done = e.tlp.tlast;
        end
      end
    end
  endtask

  task automatic pulse_req();
    pkt_req = 1'b1;
    step();
    pkt_req = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && (exp_q.size() != 0 || fifo_q.size() != 0); i++) step();
    for (int i = 0; i < 4; i++) step();
    check(tag, 80'(exp_q.size()), 80'(0));
  endtask

  initial begin
    // reset state
    pcie_rst = 1'b1;
    repeat (3) step();
    check("reset_outputs", {3'b0, tvalid, tlast, tuser, tkeep, tdata}, 80'(0));
    check("reset_rd_en", 80'(fifo_rd_en), 80'(0));
    pcie_rst = 1'b0;
    step();

    // 3-beat TLP plus bubble, second packet requested on the cycle the first tlast loads
    ready_pct = 100;
    push_packet(3, 0, 1);
    push_bubble();
    push_packet(2, 0, 0);
    pulse_req();
    check("latency_not_yet", 80'(tvalid), 80'(0));
    step();
    check("first_beat_latency", 80'(tvalid), 80'(1));
    step();
    check("contiguous_beat2", 80'(tvalid), 80'(1));
    pulse_req();
    check("contiguous_beat3", {3'b0, tvalid, tlast, tkeep}, {3'b0, 1'b1, 1'b1, 8'h0F});
    drain("directed_drain", 200);

    // truncated and over-length packets with back-pressure
    ready_pct = 50;
    push_packet(2, 1, 0);
    pulse_req();
    push_packet(6, 0, 0);
    pulse_req();
    push_packet(3, 0, 0);
    pulse_req();
    drain("limit_trunc_drain", 300);

    // complete packet present but never requested
    ready_pct = 100;
    push_packet(2, 0, 0);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tvalid) seen = 1;
    end
    check("no_start_without_req", 80'(seen), 80'(0));
    pulse_req();
    drain("late_req_drain", 100);

    // reset in the middle of a packet
    push_packet(3, 0, 0);
    pulse_req();
    step();
    pcie_rst = 1'b1;
    step();
    check("reset_mid_tvalid", 80'(tvalid), 80'(0));
    pcie_rst = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    fifo_dout  = '0;
    pop_pending = 0;
    push_packet(2, 0, 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tvalid) seen = 1;
    end
    check("pkt_cnt_cleared", 80'(seen), 80'(0));
    pulse_req();
    drain("post_reset_drain", 100);

    // randomized traffic
    ready_pct = 60;
    for (int p = 0; p < 40; p++) begin
      push_packet($urandom_range(1, 7), ($urandom_range(3) == 0), 0);
      if ($urandom_range(2) == 0) push_bubble();
      repeat ($urandom_range(0, 4)) step();
      pulse_req();
    end
    drain("random_drain", 3000);

`ifdef TLP_TX_STATS_EN
    check("stat_pkts", 80'(stat_pkts), 80'(m_pkts));
    check("stat_dsc", 80'(stat_dsc), 80'(m_dsc));
    check("stat_bubbles", 80'(stat_bubbles), 80'(m_bub));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
